// File: rtl/mem_io_resp_pkg.sv
// Shared definitions for the CPU-side memory/I/O responder: bus encodings,
// I/O window addresses and the address-region decode helper.
package mem_io_resp_pkg;

  localparam logic [1:0]  IoSel      = 2'b11;
  localparam logic [17:0] IoUart     = 18'h30000;
  localparam logic [17:0] IoClk      = 18'h30004;
  localparam int          MemByteLen = 8;

  // mem_wr encoding
  localparam logic MemWrite = 1'b1;
  localparam logic MemRead  = 1'b0;

  typedef logic [MemByteLen-1:0] byte_t;

  typedef enum logic [1:0] {
    RegionRam  = 2'd0,
    RegionIo   = 2'd1,
    RegionNone = 2'd2
  } region_e;

  // Region from the top two decoded address bits: bit 17 clear is RAM,
  // 2'b11 is the I/O window, 2'b10 is unmapped.
  function automatic region_e decode_region(input logic [1:0] hi);
    region_e r;
    if (!hi[1]) begin
      r = RegionRam;
    end else if (hi == IoSel) begin
      r = RegionIo;
    end else begin
      r = RegionNone;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_io_resp_sync_fifo.sv
// Generic synchronous FIFO with pointers, occupancy count and full/empty
// flags. The head entry is visible combinationally; an empty FIFO shows 0.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push into a full FIFO is only accepted when the head leaves in the
  // same cycle (the freed slot is the one being written).
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; power-of-two depth wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are not reset, only the pointers are.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_io_resp.sv
// Memory and I/O responder for the CPU byte bus: 2^RAM_ADDR_W byte RAM with
// one-cycle read latency, plus the 0x30000 I/O window (UART TX FIFO, RX
// holding byte, cycle counter with snapshot, program-stop flag).
module mem_io_resp
  import mem_io_resp_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        cpu_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  // ---------------- decode ----------------
  logic [17:0]           io_off;
  logic [RAM_ADDR_W-1:0] ram_addr;
  region_e               region;
  logic                  is_wr;
  logic                  acc;
  logic                  unused_addr_hi;

  assign io_off         = mem_a[17:0];
  assign ram_addr       = mem_a[RAM_ADDR_W-1:0];
  assign region         = decode_region(mem_a[17:16]);
  assign is_wr          = (mem_wr == MemWrite);
  assign unused_addr_hi = ^mem_a[31:18];

  // An access only takes effect while the CPU is not frozen.
  assign acc = cpu_rdy;

  logic ram_we, ram_re, io_wr, io_rd;
  assign ram_we = acc && (region == RegionRam) && is_wr;
  assign ram_re = acc && (region == RegionRam) && !is_wr;
  assign io_rd  = acc && (region == RegionIo)  && !is_wr;

  // ---------------- state ----------------
  logic [31:0] cnt_q, cnt_d;
  logic [31:8] snap_q, snap_d;      // low byte is returned live at snapshot time
  byte_t       rx_data_q, rx_data_d;
  logic        rx_full_q, rx_full_d;
  logic        stop_q, stop_d;

  // Writes into the I/O window are ignored once the program has stopped.
  assign io_wr = acc && (region == RegionIo) && is_wr && !stop_q;

  // ---------------- TX FIFO ----------------
  logic  uart_push, stop_push, tx_push;
  byte_t tx_push_data;
  logic  tx_full, tx_empty;

  assign uart_push    = io_wr && (io_off == IoUart) && (mem_dout != 8'h00);
  assign stop_push    = io_wr && (io_off == IoClk);
  assign tx_push      = uart_push || stop_push;
  assign tx_push_data = stop_push ? 8'h00 : mem_dout;

  sync_fifo #(
    .WIDTH (MemByteLen),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .push_i      (tx_push),
    .push_data_i (tx_push_data),
    .pop_i       (tx_ready),
    .pop_data_o  (tx_data),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  assign tx_valid     = !tx_empty;
  assign cpu_rdy      = !tx_full;
  assign rx_ready     = !rx_full_q;
  assign program_stop = stop_q;

  // ---------------- snapshot byte lanes ----------------
  byte_t snap_byte [1:3];
  for (genvar gi = 1; gi < 4; gi++) begin : g_snap_lane
    assign snap_byte[gi] = snap_q[gi*MemByteLen +: MemByteLen];
  end

  // I/O read data; anything outside the window's live registers reads 0.
  byte_t io_rdata;
  always_comb begin
    io_rdata = '0;
    if (region == RegionIo) begin
      case (io_off)
        IoUart:         io_rdata = rx_full_q ? rx_data_q : 8'h00;
        IoClk:          io_rdata = cnt_q[7:0];
        IoClk + 18'd1:  io_rdata = snap_byte[1];
        IoClk + 18'd2:  io_rdata = snap_byte[2];
        IoClk + 18'd3:  io_rdata = snap_byte[3];
        default:        io_rdata = '0;
      endcase
    end
  end

  // Next state of counter, snapshot, RX holding register and stop flag.
  always_comb begin
    cnt_d     = cnt_q + 32'd1;
    snap_d    = snap_q;
    rx_data_d = rx_data_q;
    rx_full_d = rx_full_q;
    stop_d    = stop_q;
    if (io_rd && (io_off == IoClk)) snap_d = cnt_q[31:8];
    // Capture needs an empty register, a read only clears a full one, so
    // the two never collide.
    if (io_rd && (io_off == IoUart) && rx_full_q) begin
      rx_full_d = 1'b0;
    end else if (rx_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_data_d = rx_data;
    end
    if (stop_push) stop_d = 1'b1;
  end

  // I/O state registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      rx_data_q <= '0;
      rx_full_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      rx_data_q <= rx_data_d;
      rx_full_q <= rx_full_d;
      stop_q    <= stop_d;
    end
  end

  // ---------------- RAM ----------------
  byte_t ram_q [2**RAM_ADDR_W];
  byte_t ram_rdata_q;

  // Byte RAM with registered read; contents and read register are not reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_addr] <= mem_dout;
    if (ram_re) ram_rdata_q <= ram_q[ram_addr];
  end

  // Read-data source and I/O read byte; both hold across stalled cycles
  // and writes so mem_din only changes after a performed read.
  logic  src_ram_q;
  byte_t io_rdata_q;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_ram_q  <= 1'b0;
      io_rdata_q <= '0;
    end else if (acc && !is_wr) begin
      src_ram_q <= (region == RegionRam);
      if (region != RegionRam) io_rdata_q <= io_rdata;
    end
  end

  assign mem_din = src_ram_q ? ram_rdata_q : io_rdata_q;

endmodule

// File: tb/tb_mem_io_resp.sv
// Directed bench for mem_io_resp: reset state, cycle counter snapshot, RAM,
// TX FIFO, backpressure, RX holding register, program stop and reset.
module tb_mem_io_resp;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        cpu_rdy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_io_resp #(
    .RAM_ADDR_W (17),
    .TX_DEPTH   (16)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .mem_a        (mem_a),
    .mem_wr       (mem_wr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .cpu_rdy      (cpu_rdy),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .program_stop (program_stop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  // One clock edge, then settle away from the edge before sampling.
  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  // Bus returns to an unmapped read (no side effects) after each access.
  task automatic idle_bus();
    mem_wr   = 1'b0;
    mem_a    = 32'h0002_0000;
    mem_dout = 8'h00;
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
    cycle();
    idle_bus();
  endtask

  task automatic pop_one();
    tx_ready = 1'b1;
    cycle();
    tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycle();
    cycle();
    rst_in = 1'b0;
  endtask

  initial begin
    idle_bus();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // ---- reset state ----
    do_reset();
    check_eq("rst_mem_din", mem_din, 8'h00);
    check_eq("rst_cpu_rdy", cpu_rdy, 1'b1);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_rx_ready", rx_ready, 1'b1);
    check_eq("rst_stop", program_stop, 1'b0);

    // ---- cycle counter: edge k after reset sees counter k-1 ----
    repeat (99) cycle();
    access(1'b0, 32'h0003_0004, 8'h00);  // edge 100 -> 99
    check_eq("clk_b0", mem_din, 8'h63);
    access(1'b0, 32'h0003_0005, 8'h00);
    check_eq("clk_b1", mem_din, 8'h00);
    access(1'b0, 32'h0003_0006, 8'h00);
    check_eq("clk_b2", mem_din, 8'h00);
    access(1'b0, 32'h0003_0007, 8'h00);
    check_eq("clk_b3", mem_din, 8'h00);
    repeat (200) cycle();                // edges 104..303
    access(1'b0, 32'h0003_0004, 8'h00);  // edge 304 -> 303 = 0x12F
    check_eq("clk2_b0", mem_din, 8'h2F);
    repeat (5) cycle();
    access(1'b0, 32'h0003_0005, 8'h00);
    check_eq("clk2_b1", mem_din, 8'h01);
    access(1'b0, 32'h0003_0007, 8'h00);
    check_eq("clk2_b3", mem_din, 8'h00);

    // ---- RAM ----
    access(1'b1, 32'h0000_0010, 8'hA5);
    access(1'b1, 32'h0001_FFFF, 8'h3C);
    access(1'b0, 32'h0000_0010, 8'h00);
    check_eq("ram_rd_10", mem_din, 8'hA5);
    access(1'b0, 32'h0001_FFFF, 8'h00);
    check_eq("ram_rd_top", mem_din, 8'h3C);
    access(1'b0, 32'h0002_0000, 8'h00);
    check_eq("unmapped_rd", mem_din, 8'h00);
    access(1'b1, 32'h0002_0010, 8'h77);  // must not alias onto 0x00010
    access(1'b0, 32'h0000_0010, 8'h00);
    check_eq("unmapped_wr_drop", mem_din, 8'hA5);
    access(1'b1, 32'hFFFC_0010, 8'h5E);  // upper address bits ignored
    access(1'b0, 32'h0000_0010, 8'h00);
    check_eq("ram_hi_bits", mem_din, 8'h5E);

    // ---- TX FIFO ----
    access(1'b1, 32'h0003_0001, 8'h41);  // other offset: dropped
    check_eq("tx_other_off", tx_valid, 1'b0);
    access(1'b1, 32'h0003_0000, 8'h41);
    check_eq("tx_valid_1", tx_valid, 1'b1);
    check_eq("tx_head_41", tx_data, 8'h41);
    access(1'b1, 32'h0003_0000, 8'h00);  // ignored
    access(1'b1, 32'h0003_0000, 8'h42);
    pop_one();
    check_eq("tx_head_42", tx_data, 8'h42);
    pop_one();
    check_eq("tx_empty", tx_valid, 1'b0);
    check_eq("tx_empty_data", tx_data, 8'h00);

    // ---- backpressure ----
    access(1'b0, 32'h0000_0010, 8'h00);
    check_eq("bp_pre_rd", mem_din, 8'h5E);
    for (int i = 1; i <= 16; i++) begin
      access(1'b1, 32'h0003_0000, 8'(i));
      if (i == 15) check_eq("bp_rdy_15", cpu_rdy, 1'b1);
    end
    check_eq("bp_rdy_16", cpu_rdy, 1'b0);
    access(1'b0, 32'h0001_FFFF, 8'h00);  // stalled read: not performed
    check_eq("bp_din_hold", mem_din, 8'h5E);
    check_eq("bp_still_full", cpu_rdy, 1'b0);
    mem_wr = 1'b1; mem_a = 32'h0003_0000; mem_dout = 8'h99;
    tx_ready = 1'b1;
    cycle();                             // pop only, write stalled
    tx_ready = 1'b0;
    check_eq("bp_rdy_after_pop", cpu_rdy, 1'b1);
    check_eq("bp_head_02", tx_data, 8'h02);
    cycle();                             // held write now performed
    idle_bus();
    check_eq("bp_refull", cpu_rdy, 1'b0);
    for (int k = 3; k <= 16; k++) begin
      pop_one();
      check_eq("bp_drain", tx_data, 32'(k));
    end
    pop_one();
    check_eq("bp_held_99", tx_data, 8'h99);
    pop_one();
    check_eq("bp_drained", tx_valid, 1'b0);

    // ---- RX holding register ----
    rx_valid = 1'b1; rx_data = 8'h5A;
    cycle();
    rx_valid = 1'b0;
    check_eq("rx_full", rx_ready, 1'b0);
    access(1'b0, 32'h0003_0008, 8'h00);
    check_eq("io_other_rd", mem_din, 8'h00);
    check_eq("rx_still_full", rx_ready, 1'b0);
    access(1'b0, 32'h0003_0000, 8'h00);
    check_eq("rx_rd_5a", mem_din, 8'h5A);
    check_eq("rx_emptied", rx_ready, 1'b1);
    access(1'b0, 32'h0003_0000, 8'h00);
    check_eq("rx_rd_empty", mem_din, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h11;
    cycle();
    rx_data = 8'h22;                     // full: must not be captured
    access(1'b0, 32'h0003_0000, 8'h00);
    rx_valid = 1'b0;
    check_eq("rx_full_rd", mem_din, 8'h11);
    check_eq("rx_full_rd_rdy", rx_ready, 1'b1);
    access(1'b0, 32'h0003_0000, 8'h00);
    check_eq("rx_no_capture", mem_din, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h33;    // empty: read 0 and capture
    access(1'b0, 32'h0003_0000, 8'h00);
    rx_valid = 1'b0;
    check_eq("rx_same_cyc_rd", mem_din, 8'h00);
    check_eq("rx_same_cyc_rdy", rx_ready, 1'b0);
    access(1'b0, 32'h0003_0000, 8'h00);
    check_eq("rx_rd_33", mem_din, 8'h33);

    // ---- program stop ----
    access(1'b1, 32'h0003_0000, 8'h41);
    access(1'b1, 32'h0003_0004, 8'h55);
    check_eq("stop_set", program_stop, 1'b1);
    access(1'b1, 32'h0003_0000, 8'h42);  // dropped
    check_eq("stop_head_41", tx_data, 8'h41);
    pop_one();
    check_eq("stop_zero_q", tx_valid, 1'b1);
    check_eq("stop_zero_data", tx_data, 8'h00);
    pop_one();
    check_eq("stop_drop_wr", tx_valid, 1'b0);
    check_eq("stop_sticky", program_stop, 1'b1);

    // ---- reset mid-operation ----
    rx_valid = 1'b1; rx_data = 8'h44;
    access(1'b0, 32'h0000_0010, 8'h00);
    rx_valid = 1'b0;
    check_eq("pre_rst_din", mem_din, 8'h5E);
    do_reset();
    check_eq("rst2_stop", program_stop, 1'b0);
    check_eq("rst2_rx_ready", rx_ready, 1'b1);
    check_eq("rst2_din", mem_din, 8'h00);
    access(1'b0, 32'h0003_0005, 8'h00);  // snapshot cleared
    check_eq("rst2_snap", mem_din, 8'h00);
    access(1'b0, 32'h0003_0004, 8'h00);  // edge 2 after reset -> 1
    check_eq("rst2_cnt", mem_din, 8'h01);
    access(1'b1, 32'h0003_0000, 8'h41);
    check_eq("rst2_tx_ok", tx_data, 8'h41);
    access(1'b1, 32'h0003_0000, 8'h42);
    do_reset();
    check_eq("rst3_tx_valid", tx_valid, 1'b0);
    check_eq("rst3_cpu_rdy", cpu_rdy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
